// File: rtl/pmesh_l2_pkg.sv
// Shared types and message encodings for the L2 invalidation-forward collector.
package pmesh_l2_pkg;

  localparam int NUM_SHARERS = 64;
  localparam int SHARER_W    = $clog2(NUM_SHARERS);
  localparam int TAG_W       = 26;

  localparam logic [7:0] MSG_INV_FWD    = 8'h16;
  localparam logic [7:0] MSG_INV_FWDACK = 8'h17;

  typedef enum logic [1:0] {IDLE, SEND, DONE} inv_state_e;

  typedef logic [SHARER_W-1:0]    sharer_id_t;
  typedef logic [TAG_W-1:0]       tag_t;
  typedef logic [NUM_SHARERS-1:0] share_mask_t;

  function automatic share_mask_t id_onehot(input sharer_id_t id);
    share_mask_t one;
    one = {{(NUM_SHARERS-1){1'b0}}, 1'b1};
    return one << id;
  endfunction

endpackage

// File: rtl/pmesh_l2_ffs.sv
// Find-first-set: index of the lowest set bit of vec, plus an any-bit-set flag.
module pmesh_l2_ffs #(
  parameter int N = 64,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    idx = '0;
    any = |vec;
    // Scanning downward leaves the lowest set index as the final assignment.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) idx = W'(i);
    end
  end

endmodule

// File: rtl/pmesh_l2_inv_fwd_collector.sv
// Sends one INV_FWD per sharer and gathers INV_FWDACKs, then signals completion.
// Optional ack-wait timeout enabled by PMESH_INV_ACK_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for an invalidation request
// SEND  | issuing INV_FWDs and/or collecting acks
// DONE  | presenting completion until done_ready
module pmesh_l2_inv_fwd_collector
  import pmesh_l2_pkg::*;
`ifdef PMESH_INV_ACK_TIMEOUT_EN
  #(parameter int TIMEOUT_CYCLES = 255)
`endif
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  tag_t        req_tag,
  input  share_mask_t req_share_list,
  input  sharer_id_t  req_owner,
  output logic        msg2_valid,
  input  logic        msg2_ready,
  output logic [7:0]  msg2_type,
  output sharer_id_t  msg2_dest,
  output tag_t        msg2_tag,
  input  logic        msg3_valid,
  output logic        msg3_ready,
  input  logic [7:0]  msg3_type,
  input  sharer_id_t  msg3_source,
  input  tag_t        msg3_tag,
  output logic        done_valid,
  input  logic        done_ready,
  output tag_t        done_tag,
  output logic        done_err,
  output logic        busy
);

  inv_state_e  state, state_nxt;
  share_mask_t send_mask, send_nxt, pend_mask, pend_nxt, req_mask;
  tag_t        tag, tag_nxt;
  logic        err, err_nxt;
  sharer_id_t  dest;
  logic        send_any, send_fire, ack_good, timeout;

  pmesh_l2_ffs #(.N(NUM_SHARERS)) u_ffs (
    .vec (send_mask),
    .idx (dest),
    .any (send_any)
  );

  assign req_ready  = (state == IDLE);
  assign busy       = (state != IDLE);
  assign msg2_valid = (state == SEND) && send_any;
  assign msg2_type  = (state == SEND) ? MSG_INV_FWD : 8'h00;
  assign msg2_dest  = dest;
  assign msg2_tag   = tag;
  assign msg3_ready = (state == SEND) && msg3_valid && (msg3_type == MSG_INV_FWDACK);
  assign done_valid = (state == DONE);
  assign done_tag   = done_valid ? tag : '0;
  assign done_err   = done_valid & err;

  assign send_fire = msg2_valid && msg2_ready;
  assign ack_good  = msg3_ready && (msg3_tag == tag) && pend_mask[msg3_source];
  assign req_mask  = req_share_list & ~id_onehot(req_owner);

`ifdef PMESH_INV_ACK_TIMEOUT_EN
  logic [7:0] wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
    end else if (state == IDLE && req_valid) begin
      wait_cnt <= '0;
    end else if (state == SEND) begin
      if (ack_good)
        wait_cnt <= '0;
      else if (send_mask == '0 && pend_mask != '0)
        wait_cnt <= wait_cnt + 8'd1;
    end
  end

  assign timeout = (state == SEND) && (wait_cnt == 8'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    send_nxt  = send_mask;
    pend_nxt  = pend_mask;
    tag_nxt   = tag;
    err_nxt   = err;
    case (state)
      IDLE: begin
        if (req_valid) begin
          tag_nxt   = req_tag;
          send_nxt  = req_mask;
          pend_nxt  = req_mask;
          err_nxt   = 1'b0;
          state_nxt = (req_mask == '0) ? DONE : SEND;
        end
      end
      SEND: begin
        if (send_fire) send_nxt = send_mask & ~id_onehot(dest);
        if (msg3_ready) begin
          if (ack_good) pend_nxt = pend_mask & ~id_onehot(msg3_source);
          else          err_nxt  = 1'b1;
        end
        if (timeout) begin
          // Outstanding acks are abandoned; the round reports an error.
          send_nxt  = '0;
          pend_nxt  = '0;
          err_nxt   = 1'b1;
          state_nxt = DONE;
        end else if (send_nxt == '0 && pend_nxt == '0) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (done_ready) begin
          err_nxt   = 1'b0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      send_mask <= '0;
      pend_mask <= '0;
      tag       <= '0;
      err       <= 1'b0;
    end else begin
      state     <= state_nxt;
      send_mask <= send_nxt;
      pend_mask <= pend_nxt;
      tag       <= tag_nxt;
      err       <= err_nxt;
    end
  end

endmodule

// File: tb/tb_pmesh_l2_inv_fwd_collector.sv
// Bench for pmesh_l2_inv_fwd_collector: directed rounds plus random rounds against a set-based model.
module tb_pmesh_l2_inv_fwd_collector;
  import pmesh_l2_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready;
  tag_t        req_tag;
  share_mask_t req_share_list;
  sharer_id_t  req_owner;
  logic        msg2_valid, msg2_ready;
  logic [7:0]  msg2_type;
  sharer_id_t  msg2_dest;
  tag_t        msg2_tag;
  logic        msg3_valid, msg3_ready;
  logic [7:0]  msg3_type;
  sharer_id_t  msg3_source;
  tag_t        msg3_tag;
  logic        done_valid, done_ready;
  tag_t        done_tag;
  logic        done_err;
  logic        busy;

  pmesh_l2_inv_fwd_collector dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_tag(req_tag),
    .req_share_list(req_share_list), .req_owner(req_owner),
    .msg2_valid(msg2_valid), .msg2_ready(msg2_ready), .msg2_type(msg2_type),
    .msg2_dest(msg2_dest), .msg2_tag(msg2_tag),
    .msg3_valid(msg3_valid), .msg3_ready(msg3_ready), .msg3_type(msg3_type),
    .msg3_source(msg3_source), .msg3_tag(msg3_tag),
    .done_valid(done_valid), .done_ready(done_ready), .done_tag(done_tag),
    .done_err(done_err), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: phase 0 = idle, 1 = sending/collecting, 2 = completion pending.
  int          phase = 0;
  tag_t        m_tag;
  bit          m_err;
  int          sendq[$];
  bit [63:0]   m_pend;
  int          m_wait;
  int          n_sent = 0;
  int          n_done = 0;
  bit          exp_m2v, prev_stall, consume, good, tmo, waiting;
  sharer_id_t  prev_dest;
  tag_t        prev_tag;

  always @(negedge clk) begin
    if (!rst_n) begin
      phase = 0; m_err = 0; m_pend = '0; sendq.delete(); m_wait = 0; prev_stall = 0;
      chk("rst_req_ready", req_ready, 1);
      chk("rst_msg2_valid", msg2_valid, 0);
      chk("rst_msg2_type", msg2_type, 0);
      chk("rst_msg2_dest", msg2_dest, 0);
      chk("rst_msg2_tag", msg2_tag, 0);
      chk("rst_msg3_ready", msg3_ready, 0);
      chk("rst_done_valid", done_valid, 0);
      chk("rst_done_tag", done_tag, 0);
      chk("rst_done_err", done_err, 0);
      chk("rst_busy", busy, 0);
    end else begin
      exp_m2v = (phase == 1) && (sendq.size() > 0);
      consume = (phase == 1) && msg3_valid && (msg3_type == 8'h17);
      chk("req_ready", req_ready, phase == 0);
      chk("busy", busy, phase != 0);
      chk("msg2_valid", msg2_valid, exp_m2v);
      chk("msg3_ready", msg3_ready, consume);
      chk("done_valid", done_valid, phase == 2);
      if (exp_m2v) begin
        chk("msg2_dest", msg2_dest, sendq[0]);
        chk("msg2_tag", msg2_tag, m_tag);
        chk("msg2_type", msg2_type, 8'h16);
        if (prev_stall) begin
          chk("hold_dest", msg2_dest, prev_dest);
          chk("hold_tag", msg2_tag, prev_tag);
        end
      end
      if (phase == 2) begin
        chk("done_tag", done_tag, m_tag);
        chk("done_err", done_err, m_err);
      end
      prev_stall = exp_m2v && !msg2_ready;
      prev_dest = msg2_dest;
      prev_tag = msg2_tag;

      case (phase)
        0: if (req_valid) begin
          m_tag = req_tag; m_err = 0; m_pend = '0; sendq.delete(); m_wait = 0;
          for (int i = 0; i < 64; i++)
            if (req_share_list[i] && i != int'(req_owner)) begin
              sendq.push_back(i);
              m_pend[i] = 1'b1;
            end
          phase = (sendq.size() > 0) ? 1 : 2;
        end
        1: begin
          tmo = 0;
`ifdef PMESH_INV_ACK_TIMEOUT_EN
          tmo = (m_wait == 255);
`endif
          waiting = (sendq.size() == 0) && (m_pend != '0);
          good = 0;
          if (consume) begin
            good = (msg3_tag == m_tag) && m_pend[msg3_source];
            if (good) m_pend[msg3_source] = 1'b0;
            else m_err = 1;
          end
          if (good) m_wait = 0;
          else if (waiting) m_wait++;
          if (exp_m2v && msg2_ready) begin
            void'(sendq.pop_front());
            n_sent++;
          end
          if (tmo) begin
            phase = 2; m_err = 1; m_pend = '0; sendq.delete();
          end else if (sendq.size() == 0 && m_pend == '0) begin
            phase = 2;
          end
        end
        default: if (done_ready) begin
          phase = 0; m_err = 0; n_done++;
        end
      endcase
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    req_valid = 0; req_tag = '0; req_share_list = '0; req_owner = '0;
    msg2_ready = 0; msg3_valid = 0; msg3_type = '0; msg3_source = '0; msg3_tag = '0;
    done_ready = 0;
  endtask

  task automatic start_round(input share_mask_t share, input sharer_id_t owner, input tag_t tag);
    int c;
    for (c = 0; c < 50 && !req_ready; c++) step();
    chk("req_wait", req_ready, 1);
    req_valid = 1; req_share_list = share; req_owner = owner; req_tag = tag;
    step();
    req_valid = 0;
  endtask

  task automatic ack(input sharer_id_t src, input tag_t tag, input logic [7:0] typ);
    msg3_valid = 1; msg3_source = src; msg3_tag = tag; msg3_type = typ;
    step();
    msg3_valid = 0;
  endtask

  task automatic wait_sent(input int target);
    for (int c = 0; c < 100 && n_sent < target; c++) step();
    chk("sent_count", n_sent, target);
  endtask

  task automatic finish_round(input logic exp_err);
    int c;
    for (c = 0; c < 400 && !done_valid; c++) step();
    chk("done_seen", done_valid, 1);
    chk("round_err", done_err, exp_err);
    done_ready = 1;
    step();
    done_ready = 0;
  endtask

  tag_t t;
  int   s0, d0, base;

  initial begin
    rst_n = 0;
    idle_inputs();
    step(); step();
    rst_n = 1;
    step();

    // Two sharers, owner excluded, sends back to back.
    t = tag_t'($urandom);
    msg2_ready = 1; s0 = n_sent;
    start_round(64'h0000_0000_0000_000B, 6'd1, t);
    wait_sent(s0 + 2);
    ack(6'd3, t, 8'h17);
    ack(6'd0, t, 8'h17);
    finish_round(0);

    // Owner is the only sharer: completion without any INV_FWD.
    t = tag_t'($urandom); s0 = n_sent;
    start_round(64'h1 << 9, 6'd9, t);
    chk("owner_only_done", done_valid, 1);
    chk("owner_only_tag", done_tag, t);
    finish_round(0);
    chk("owner_only_nosend", n_sent, s0);

    // Backpressure for four cycles mid-send.
    t = tag_t'($urandom); s0 = n_sent;
    msg2_ready = 1;
    start_round(64'h0000_00F0_0000_0F00, 6'd63, t);
    step();
    msg2_ready = 0;
    repeat (4) step();
    msg2_ready = 1;
    wait_sent(s0 + 8);
    for (int i = 0; i < 64; i++) if (m_pend[i]) ack(sharer_id_t'(i), t, 8'h17);
    finish_round(0);

    // Wrong-tag ack flags error; non-ack type is ignored.
    t = tag_t'($urandom);
    start_round(64'h30, 6'd0, t);
    ack(6'd4, t ^ tag_t'(1), 8'h17);
    ack(6'd4, t, 8'h05);
    chk("pend_after_stray", m_pend, 64'h30);
    ack(6'd4, t, 8'h17);
    ack(6'd5, t, 8'h17);
    wait_sent(n_sent + 0);
    finish_round(1);

    // Early ack for a sharer whose INV_FWD is still queued.
    t = tag_t'($urandom); s0 = n_sent;
    msg2_ready = 0;
    start_round(64'h21, 6'd2, t);
    ack(6'd5, t, 8'h17);
    chk("early_ack_busy", busy, 1);
    msg2_ready = 1;
    wait_sent(s0 + 2);
    ack(6'd0, t, 8'h17);
    finish_round(0);

    // Reset mid-SEND, then a normal round.
    t = tag_t'($urandom);
    msg2_ready = 0;
    start_round(64'hFF00, 6'd0, t);
    step();
    rst_n = 0;
    #1;
    chk("abort_msg2_valid", msg2_valid, 0);
    chk("abort_busy", busy, 0);
    chk("abort_req_ready", req_ready, 1);
    chk("abort_done_valid", done_valid, 0);
    step();
    rst_n = 1;
    step();
    t = tag_t'($urandom); s0 = n_sent;
    msg2_ready = 1;
    start_round(64'h6, 6'd0, t);
    wait_sent(s0 + 2);
    ack(6'd1, t, 8'h17);
`ifdef PMESH_INV_ACK_TIMEOUT_EN
    finish_round(1);
`else
    repeat (300) step();
    chk("no_timeout_busy", busy, 1);
    ack(6'd2, t, 8'h17);
    finish_round(0);
`endif

    // Random rounds with backpressure, stray acks and ignored message types.
    for (int r = 0; r < 25; r++) begin
      t = tag_t'($urandom);
      d0 = n_done;
      start_round({$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom},
                  sharer_id_t'($urandom_range(0, 63)), t);
      for (int c = 0; c < 800 && n_done == d0; c++) begin
        msg2_ready = ($urandom_range(0, 3) != 0);
        done_ready = ($urandom_range(0, 1) != 0);
        msg3_valid = 0;
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4: begin
            base = $urandom_range(0, 63);
            for (int k = 0; k < 64; k++)
              if (m_pend[(base + k) % 64]) begin
                msg3_valid = 1; msg3_type = 8'h17; msg3_tag = t;
                msg3_source = sharer_id_t'((base + k) % 64);
                break;
              end
          end
          5: begin
            msg3_valid = 1; msg3_type = 8'h17; msg3_tag = t ^ tag_t'($urandom_range(1, 255));
            msg3_source = sharer_id_t'($urandom_range(0, 63));
          end
          6: begin
            msg3_valid = 1; msg3_type = 8'h05; msg3_tag = t;
            msg3_source = sharer_id_t'($urandom_range(0, 63));
          end
          default: ;
        endcase
        step();
      end
      idle_inputs();
      chk("rnd_round_done", n_done, d0 + 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
